// File: rtl/snake_game_if.sv
// Handshake and control bundle between the snake game sequencer and its
// surroundings: buttons, datapath step handshake, food handshake and status.
interface snake_game_if;
  logic       l;
  logic       r;
  logic       u;
  logic       d;
  logic       step_done;
  logic       ate;
  logic       collide;
  logic       food_ack;
  logic       food_on_snake;
  logic       step;
  logic [3:0] motion;
  logic       food_req;
  logic       running;
  logic       game_over;
  logic       late;
  logic [7:0] score;

  // Sequencer side: consumes buttons and handshake returns, drives strobes and status
  modport master (
    input  l, r, u, d,
    input  step_done, ate, collide,
    input  food_ack, food_on_snake,
    output step, motion, food_req, running, game_over, late, score
  );

  // Environment side: datapath, food generator and button pads
  modport slave (
    output l, r, u, d,
    output step_done, ate, collide,
    output food_ack, food_on_snake,
    input  step, motion, food_req, running, game_over, late, score
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: idle/run/over state machine, move tick generator,
// button synchronizer and direction filter, step strobe, food placement
// request/ack sequencing with bounded retries, and a saturating score.
module snake_game_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int OVER_TICKS = 3,
  parameter int MAX_RETRY  = 4
) (
  input  logic         clk,
  input  logic         rst,
  snake_game_if.master bus
);

  localparam int CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int OVER_W  = (OVER_TICKS > 1) ? $clog2(OVER_TICKS) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FOOD     = 3'd1;
  localparam logic [2:0] S_RUN_WAIT = 3'd2;
  localparam logic [2:0] S_STEP     = 3'd3;
  localparam logic [2:0] S_OVER     = 3'd4;

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_R = 4'b0100;
  localparam logic [3:0] DIR_U = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         sync1_q, sync2_q;
  logic [3:0]         motion_q, motion_d;
  logic [3:0]         pending_q, pending_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [OVER_W-1:0]  over_cnt_q, over_cnt_d;
  logic [7:0]         score_q, score_d;
  logic               step_q, step_d;
  logic               food_req_q, food_req_d;
  logic               running_q, running_d;
  logic               game_over_q, game_over_d;
  logic               late_q, late_d;

  logic       tick;
  logic       press_any;
  logic [3:0] press_dir;
  logic [3:0] motion_rev;

  // Priority-encode the synchronized buttons (l > r > u > d) and form the
  // reverse of the committed motion by swapping l<->r and u<->d.
  always_comb begin
    press_dir = 4'b0000;
    if (sync2_q[3])      press_dir = DIR_L;
    else if (sync2_q[2]) press_dir = DIR_R;
    else if (sync2_q[1]) press_dir = DIR_U;
    else if (sync2_q[0]) press_dir = DIR_D;
    press_any  = |sync2_q;
    motion_rev = {motion_q[2], motion_q[3], motion_q[0], motion_q[1]};
  end

  // Next-state logic for the game sequencer, tick counter and outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    motion_d    = motion_q;
    pending_d   = pending_q;
    retry_d     = retry_q;
    over_cnt_d  = over_cnt_q;
    score_d     = score_q;
    step_d      = 1'b0;
    food_req_d  = food_req_q;
    late_d      = late_q;

    tick = (state_q != S_IDLE) && (cnt_q == CNT_W'(TICK_DIV - 1));

    // The tick counter only runs once a game has started
    if (state_q == S_IDLE || tick) cnt_d = '0;
    else                           cnt_d = cnt_q + 1'b1;

    // During play, any press that does not fold the snake back onto itself
    // becomes the candidate for the next step
    if ((state_q == S_FOOD || state_q == S_RUN_WAIT || state_q == S_STEP) &&
        press_any && (press_dir != motion_rev))
      pending_d = press_dir;

    // A tick that cannot be honoured is dropped and flagged
    if (tick && (state_q == S_STEP || state_q == S_FOOD)) late_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (press_any) begin
          state_d    = S_FOOD;
          score_d    = 8'd0;
          motion_d   = press_dir;
          pending_d  = press_dir;
          food_req_d = 1'b1;
          retry_d    = '0;
        end
      end
      S_FOOD: begin
        if (food_req_q && bus.food_ack) begin
          food_req_d = 1'b0;
          if (bus.food_on_snake && (retry_q < RETRY_W'(MAX_RETRY))) begin
            retry_d = retry_q + 1'b1;
          end else begin
            retry_d = '0;
            state_d = S_RUN_WAIT;
          end
        end else if (!food_req_q) begin
          // Re-request after the one-cycle gap that follows a rejection
          food_req_d = 1'b1;
        end
      end
      S_RUN_WAIT: begin
        if (tick) begin
          state_d  = S_STEP;
          motion_d = pending_q;
          step_d   = 1'b1;
        end
      end
      S_STEP: begin
        if (bus.step_done) begin
          if (bus.collide) begin
            state_d    = S_OVER;
            over_cnt_d = '0;
          end else if (bus.ate) begin
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
            food_req_d = 1'b1;
            state_d    = S_FOOD;
          end else begin
            state_d = S_RUN_WAIT;
          end
        end
      end
      S_OVER: begin
        if (tick) begin
          if (over_cnt_q == OVER_W'(OVER_TICKS - 1)) begin
            state_d = S_IDLE;
            late_d  = 1'b0;
          end else begin
            over_cnt_d = over_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    running_d   = (state_d == S_FOOD) || (state_d == S_RUN_WAIT) || (state_d == S_STEP);
    game_over_d = (state_d == S_OVER);
  end

  // State, counters and registered outputs; reset abandons any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sync1_q     <= 4'b0000;
      sync2_q     <= 4'b0000;
      motion_q    <= DIR_L;
      pending_q   <= DIR_L;
      retry_q     <= '0;
      over_cnt_q  <= '0;
      score_q     <= 8'd0;
      step_q      <= 1'b0;
      food_req_q  <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= {bus.l, bus.r, bus.u, bus.d};
      sync2_q     <= sync1_q;
      motion_q    <= motion_d;
      pending_q   <= pending_d;
      retry_q     <= retry_d;
      over_cnt_q  <= over_cnt_d;
      score_q     <= score_d;
      step_q      <= step_d;
      food_req_q  <= food_req_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
      late_q      <= late_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.motion    = motion_q;
  assign bus.food_req  = food_req_q;
  assign bus.running   = running_q;
  assign bus.game_over = game_over_q;
  assign bus.late      = late_q;
  assign bus.score     = score_q;

endmodule
